// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU datapath and its issue front end.
// Contents:
//   - the ten 4-bit ALU opcodes
//   - the RV32I funct3 codes for the OP/OP-IMM group
//   - the issue FSM state enum
//   - bit positions of the {N,Z,C,V} status nibble
//   - the decode result struct and a helper that flags shift opcodes
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam int STAT_N = 3;
   localparam int STAT_Z = 2;
   localparam int STAT_C = 1;
   localparam int STAT_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] op;
      logic       illegal;
   } decode_t;

   // Shift opcodes are the only ones whose B operand is a shift amount.
   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if
// Request/response bundle between the decode stage and the ALU issue block.
// Parameter: C_WIDTH - operand/result width.
// Request side  : in_valid, in_ready, in_funct3, in_funct7_5, in_is_imm,
//                 in_a, in_b
// Response side : out_valid, out_ready, out_result, out_status, out_illegal
// Modports:
//   master - the producer of requests and consumer of results
//   slave  - the issue block itself
interface alu_issue_if #(parameter int C_WIDTH = 32);

   logic               in_valid;
   logic               in_ready;
   logic [2:0]         in_funct3;
   logic               in_funct7_5;
   logic               in_is_imm;
   logic [C_WIDTH-1:0] in_a;
   logic [C_WIDTH-1:0] in_b;
   logic               out_valid;
   logic               out_ready;
   logic [C_WIDTH-1:0] out_result;
   logic [3:0]         out_status;
   logic               out_illegal;

   modport master (
      output in_valid, in_funct3, in_funct7_5, in_is_imm, in_a, in_b,
      output out_ready,
      input  in_ready, out_valid, out_result, out_status, out_illegal
   );

   modport slave (
      input  in_valid, in_funct3, in_funct7_5, in_is_imm, in_a, in_b,
      input  out_ready,
      output in_ready, out_valid, out_result, out_status, out_illegal
   );

endinterface

// File: rtl/alu.sv
// alu
// Purely combinational integer ALU.
// Parameter: C_WIDTH - operand/result width.
// Ports:
//   op     in  4        ALU opcode (see alu_pkg)
//   a      in  C_WIDTH  operand A
//   b      in  C_WIDTH  operand B
//   result out C_WIDTH  operation result
//   status out 4        {N,Z,C,V}; C and V are only driven for ADD/SUB
module alu
   import alu_pkg::*;
#(
   parameter int C_WIDTH = 32
) (
   input  logic [3:0]         op,
   input  logic [C_WIDTH-1:0] a,
   input  logic [C_WIDTH-1:0] b,
   output logic [C_WIDTH-1:0] result,
   output logic [3:0]         status
);

   logic [C_WIDTH-1:0] b_eff;
   logic               cin;
   logic [C_WIDTH:0]   sum;
   logic               arith;

   // Subtraction reuses the adder as A + ~B + 1, so carry means "no borrow".
   // Overflow is the usual same-sign-in, different-sign-out test applied to
   // the effective adder operands, which covers both ADD and SUB.
   always_comb begin
      arith  = (op == OP_ADD) || (op == OP_SUB);
      b_eff  = (op == OP_SUB) ? ~b : b;
      cin    = (op == OP_SUB);
      sum    = {1'b0, a} + {1'b0, b_eff} + {{C_WIDTH{1'b0}}, cin};
      result = '0;
      case (op)
         OP_ADD,
         OP_SUB:  result = sum[C_WIDTH-1:0];
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = {{(C_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: result = {{(C_WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  result = a << b;
         OP_SRL:  result = a >> b;
         OP_SRA:  result = $unsigned($signed(a) >>> b);
         default: result = '0;
      endcase
      status         = '0;
      status[STAT_N] = result[C_WIDTH-1];
      status[STAT_Z] = (result == '0);
      if (arith) begin
         status[STAT_C] = sum[C_WIDTH];
         status[STAT_V] = (a[C_WIDTH-1] == b_eff[C_WIDTH-1]) &&
                          (sum[C_WIDTH-1] != a[C_WIDTH-1]);
      end
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
// Sequential front end for the alu datapath. Accepts one RV32I OP/OP-IMM
// request per handshake, decodes funct3/funct7[5] into an ALU opcode,
// registers the operands, runs the ALU for one cycle and presents the
// registered result until the consumer takes it.
// Parameter: C_WIDTH - operand/result width (power of two, >= 8).
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of alu_issue_if (request and result handshakes)
module alu_issue
   import alu_pkg::*;
#(
   parameter int C_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.slave  bus
);

   localparam int SHW = $clog2(C_WIDTH);

   state_t             state_q;
   state_t             state_d;
   logic [3:0]         op_q;
   logic [C_WIDTH-1:0] a_q;
   logic [C_WIDTH-1:0] b_q;
   logic               ill_q;
   logic [C_WIDTH-1:0] result_q;
   logic [3:0]         status_q;
   logic               illegal_q;
   logic [C_WIDTH-1:0] alu_result;
   logic [3:0]         alu_status;
   decode_t            dec;
   logic [C_WIDTH-1:0] b_in;
   logic               accept;

   // funct3/funct7[5] to ALU opcode. Bit 30 selects SUB only for register
   // OP (for OP-IMM it is just an immediate bit), selects SRA for both
   // forms, and is otherwise illegal on OP and on the SLLI encoding.
   function automatic decode_t decode(input logic [2:0] f3,
                                      input logic       f7_5,
                                      input logic       imm);
      decode_t d;
      d.op      = OP_ADD;
      d.illegal = 1'b0;
      case (f3)
         F3_ADD:  d.op = (f7_5 && !imm) ? OP_SUB : OP_ADD;
         F3_SLL:  d.op = OP_SLL;
         F3_SLT:  d.op = OP_SLT;
         F3_SLTU: d.op = OP_SLTU;
         F3_XOR:  d.op = OP_XOR;
         F3_SR:   d.op = f7_5 ? OP_SRA : OP_SRL;
         F3_OR:   d.op = OP_OR;
         F3_AND:  d.op = OP_AND;
         default: d.op = OP_ADD;
      endcase
      if (!imm && f7_5 && (f3 != F3_ADD) && (f3 != F3_SR)) begin
         d.illegal = 1'b1;
      end
      if (imm && f7_5 && (f3 == F3_SLL)) begin
         d.illegal = 1'b1;
      end
      return d;
   endfunction

   // Decode the incoming request and trim shift amounts to log2(width) bits
   // so that e.g. an immediate of 0x21 shifts by 1 rather than clearing.
   always_comb begin
      dec  = decode(bus.in_funct3, bus.in_funct7_5, bus.in_is_imm);
      b_in = bus.in_b;
      if (is_shift(dec.op)) begin
         b_in = {{(C_WIDTH-SHW){1'b0}}, bus.in_b[SHW-1:0]};
      end
   end

   // A new request can be taken when idle, or when the held result is being
   // retired in the same cycle, which gives back-to-back issue.
   assign bus.in_ready    = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign accept          = bus.in_valid && bus.in_ready;
   assign bus.out_valid   = (state_q == DONE);
   assign bus.out_result  = result_q;
   assign bus.out_status  = status_q;
   assign bus.out_illegal = illegal_q;

   // Next-state logic: IDLE waits for work, EXEC always lasts one cycle,
   // DONE holds until the consumer takes the result.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = bus.in_valid ? EXEC : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Operands are captured only on the accept
   // edge; outputs are captured only at the end of EXEC, so they stay put in
   // DONE regardless of what the request side is doing. An illegal request
   // overrides the ALU with a zero result and just the Z flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= OP_ADD;
         a_q       <= '0;
         b_q       <= '0;
         ill_q     <= 1'b0;
         result_q  <= '0;
         status_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= dec.op;
            a_q   <= bus.in_a;
            b_q   <= b_in;
            ill_q <= dec.illegal;
         end
         if (state_q == EXEC) begin
            result_q  <= ill_q ? '0 : alu_result;
            status_q  <= ill_q ? 4'b0100 : alu_status;
            illegal_q <= ill_q;
         end
      end
   end

   alu #(
      .C_WIDTH (C_WIDTH)
   ) u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .status (alu_status)
   );

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
// Directed testbench for alu_issue at C_WIDTH=32. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_alu_issue;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   alu_issue_if #(.C_WIDTH(32)) bus ();

   alu_issue #(.C_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [2:0]  f3;
      logic        f75;
      logic        imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  st;
      logic        ill;
      string       name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one request on a falling edge, hold it across the next rising
   // edge, then drop valid and scramble the fields so any late sampling of
   // the request would corrupt the result.
   task automatic drive_req(input logic [2:0] f3, input logic f75, input logic imm,
                            input logic [31:0] a, input logic [31:0] b);
      bus.in_funct3   = f3;
      bus.in_funct7_5 = f75;
      bus.in_is_imm   = imm;
      bus.in_a        = a;
      bus.in_b        = b;
      bus.in_valid    = 1'b1;
      @(negedge clk);
      bus.in_valid    = 1'b0;
      bus.in_funct3   = ~f3;
      bus.in_funct7_5 = ~f75;
      bus.in_is_imm   = ~imm;
      bus.in_a        = 32'hDEAD_BEEF;
      bus.in_b        = 32'h0BAD_F00D;
   endtask

   // Bounded wait for out_valid; n is the number of falling edges waited.
   task automatic wait_valid(output int n);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_funct3 = 3'b000;
      bus.in_funct7_5 = 1'b0;
      bus.in_is_imm = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_result !== 32'h0) $display("[TB] FAIL reset_result: got %h want 00000000", bus.out_result);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_status !== 4'b0000) $display("[TB] FAIL reset_status: got %b want 0000", bus.out_status);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_illegal !== 1'b0) $display("[TB] FAIL reset_illegal: got %b want 0", bus.out_illegal);
      else pass_cnt++;
   endtask

   // ADD overflow case with exact latency: still busy one cycle after the
   // accept edge, valid after the second edge, gone once consumed.
   task automatic test_add_latency();
      bus.out_ready = 1'b1;
      drive_req(3'b000, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1);
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL add_valid_t1: got %b want 0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b0) $display("[TB] FAIL add_ready_exec: got %b want 0", bus.in_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid !== 1'b1) $display("[TB] FAIL add_valid_t2: got %b want 1", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_result !== 32'h8000_0000) $display("[TB] FAIL add_result: got %h want 80000000", bus.out_result);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_status !== 4'b1001) $display("[TB] FAIL add_status: got %b want 1001", bus.out_status);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_illegal !== 1'b0) $display("[TB] FAIL add_illegal: got %b want 0", bus.out_illegal);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL add_retired: got %b want 0", bus.out_valid);
      else pass_cnt++;
   endtask

   // Table of decode, masking and illegal-encoding cases.
   task automatic test_decode();
      int n;
      vecs.delete();
      vecs.push_back('{3'b000, 1'b1, 1'b0, 32'h5,         32'h5,         32'h0,         4'b0110, 1'b0, "sub"});
      vecs.push_back('{3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h21,        32'hC000_0000, 4'b1000, 1'b0, "srai"});
      vecs.push_back('{3'b110, 1'b1, 1'b0, 32'hF0,        32'h0F,        32'h0,         4'b0100, 1'b1, "op_or_f7"});
      vecs.push_back('{3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1'b0, "slt"});
      vecs.push_back('{3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b0100, 1'b0, "sltu"});
      vecs.push_back('{3'b100, 1'b0, 1'b1, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 4'b1000, 1'b0, "xori"});
      vecs.push_back('{3'b111, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 4'b0000, 1'b0, "and"});
      vecs.push_back('{3'b001, 1'b0, 1'b0, 32'h1,         32'h24,        32'h10,        4'b0000, 1'b0, "sll_mask"});
      vecs.push_back('{3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h21,        32'h4000_0000, 4'b0000, 1'b0, "srli"});
      vecs.push_back('{3'b101, 1'b1, 1'b0, 32'h8000_0010, 32'h4,         32'hF800_0001, 4'b1000, 1'b0, "sra"});
      vecs.push_back('{3'b001, 1'b1, 1'b1, 32'h1,         32'h1,         32'h0,         4'b0100, 1'b1, "slli_f7"});
      vecs.push_back('{3'b010, 1'b1, 1'b0, 32'h3,         32'h7,         32'h0,         4'b0100, 1'b1, "op_slt_f7"});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 32'hF0,        32'hFFFF_F80F, 32'hFFFF_F8FF, 4'b1000, 1'b0, "ori_f7"});
      vecs.push_back('{3'b000, 1'b1, 1'b1, 32'h5,         32'hFFFF_FFFB, 32'h0,         4'b0110, 1'b0, "addi_f7"});
      bus.out_ready = 1'b1;
      foreach (vecs[i]) begin
         drive_req(vecs[i].f3, vecs[i].f75, vecs[i].imm, vecs[i].a, vecs[i].b);
         wait_valid(n);
         total_cnt++;
         if (n >= 10) $display("[TB] FAIL %s_timeout: out_valid never rose in %0d cycles", vecs[i].name, n);
         else pass_cnt++;
         total_cnt++;
         if (bus.out_result !== vecs[i].res)
            $display("[TB] FAIL %s_result: got %h want %h", vecs[i].name, bus.out_result, vecs[i].res);
         else pass_cnt++;
         total_cnt++;
         if (bus.out_status !== vecs[i].st)
            $display("[TB] FAIL %s_status: got %b want %b", vecs[i].name, bus.out_status, vecs[i].st);
         else pass_cnt++;
         total_cnt++;
         if (bus.out_illegal !== vecs[i].ill)
            $display("[TB] FAIL %s_illegal: got %b want %b", vecs[i].name, bus.out_illegal, vecs[i].ill);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   // Held result with a pending request: nothing moves until out_ready,
   // then retire and accept happen on the same edge.
   task automatic test_backpressure();
      int n;
      bus.out_ready = 1'b0;
      drive_req(3'b000, 1'b0, 1'b0, 32'h3, 32'h4);
      wait_valid(n);
      total_cnt++;
      if (n >= 10) $display("[TB] FAIL bp_timeout: out_valid never rose in %0d cycles", n);
      else pass_cnt++;
      bus.in_funct3   = 3'b100;
      bus.in_funct7_5 = 1'b0;
      bus.in_is_imm   = 1'b0;
      bus.in_a        = 32'hFF;
      bus.in_b        = 32'h0F;
      bus.in_valid    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total_cnt++;
         if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid[%0d]: got %b want 1", k, bus.out_valid);
         else pass_cnt++;
         total_cnt++;
         if (bus.out_result !== 32'h7) $display("[TB] FAIL bp_hold_result[%0d]: got %h want 00000007", k, bus.out_result);
         else pass_cnt++;
         total_cnt++;
         if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_hold_ready[%0d]: got %b want 0", k, bus.in_ready);
         else pass_cnt++;
      end
      bus.out_ready = 1'b1;
      #1;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b want 1", bus.in_ready);
      else pass_cnt++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_new_exec: got %b want 0", bus.out_valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_new_valid: got %b want 1", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_result !== 32'hF0) $display("[TB] FAIL bp_new_result: got %h want 000000f0", bus.out_result);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_status !== 4'b0000) $display("[TB] FAIL bp_new_status: got %b want 0000", bus.out_status);
      else pass_cnt++;
      @(negedge clk);
   endtask

   // in_valid held high with out_ready high: one result every two cycles.
   task automatic test_back_to_back();
      bus.out_ready   = 1'b1;
      bus.in_funct3   = 3'b000;
      bus.in_funct7_5 = 1'b0;
      bus.in_is_imm   = 1'b0;
      bus.in_a        = 32'h1;
      bus.in_b        = 32'h2;
      bus.in_valid    = 1'b1;
      @(negedge clk);
      bus.in_funct7_5 = 1'b1;
      bus.in_a        = 32'hA;
      bus.in_b        = 32'h3;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL b2b_first_exec: got %b want 0", bus.out_valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid !== 1'b1) $display("[TB] FAIL b2b_first_valid: got %b want 1", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_result !== 32'h3) $display("[TB] FAIL b2b_first_result: got %h want 00000003", bus.out_result);
      else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("[TB] FAIL b2b_ready: got %b want 1", bus.in_ready);
      else pass_cnt++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL b2b_second_exec: got %b want 0", bus.out_valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid !== 1'b1) $display("[TB] FAIL b2b_second_valid: got %b want 1", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_result !== 32'h7) $display("[TB] FAIL b2b_second_result: got %h want 00000007", bus.out_result);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_status !== 4'b0010) $display("[TB] FAIL b2b_second_status: got %b want 0010", bus.out_status);
      else pass_cnt++;
   endtask

   // Reset while in EXEC (outputs still hold the previous nonzero result):
   // everything returns to reset values and no valid pulse follows.
   task automatic test_reset_exec();
      bus.out_ready = 1'b1;
      drive_req(3'b000, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("[TB] FAIL rstx_in_ready: got %b want 1", bus.in_ready);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_result !== 32'h0) $display("[TB] FAIL rstx_result: got %h want 00000000", bus.out_result);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_status !== 4'b0000) $display("[TB] FAIL rstx_status: got %b want 0000", bus.out_status);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_illegal !== 1'b0) $display("[TB] FAIL rstx_illegal: got %b want 0", bus.out_illegal);
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         total_cnt++;
         if (bus.out_valid !== 1'b0) $display("[TB] FAIL rstx_no_valid[%0d]: got %b want 0", k, bus.out_valid);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      @(negedge clk);
      test_reset();
      test_add_latency();
      test_decode();
      test_backpressure();
      test_back_to_back();
      test_reset_exec();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequential front end for the `alu` datapath. It accepts one RV32I-style OP/OP-IMM request per handshake and decodes `funct3`/`funct7[5]` into the 4-bit ALU opcode. It registers the operands, runs the ALU for one cycle, and holds the registered `Result`/`Status` on a valid/ready output port until it is consumed. It sits between the decode stage and writeback in the single-issue core.

## Interface
- `C_WIDTH`, 32: operand/result width, passed to the ALU instance; power of two, ≥ 8.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_funct3`  in  3  RV32I funct3.
- `in_funct7_5`  in  1  instruction bit 30.
- `in_is_imm`  in  1  1 = OP-IMM, 0 = OP.
- `in_a`  in  C_WIDTH  operand A (rs1).
- `in_b`  in  C_WIDTH  operand B (rs2 or sign-extended immediate).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  C_WIDTH  registered ALU result.
- `out_status`  out  4  registered {N,Z,C,V}.
- `out_illegal`  out  1  request was an undefined encoding.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, latch decoded opcode, A, masked B and the illegal flag, then go to EXEC.
  - EXEC: ALU evaluates the registered operands. Capture `Result`, `Status` and illegal into the output registers, then go to DONE.
  - DONE: `out_valid`=1; outputs stable.
    - `out_ready`=1 and `in_valid`=0: go to IDLE.
    - `out_ready`=1 and `in_valid`=1: accept the new request in the same cycle and go to EXEC.
    - `out_ready`=0: stay in DONE.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`).
- Decode from funct3 to ALU opcode:
  - 000 → ADD 0000; SUB 0001 when `in_funct7_5`=1 and `in_is_imm`=0.
  - 001 → SLL 1000.
  - 010 → SLT 0101.
  - 011 → SLTU 0111.
  - 100 → XOR 0100.
  - 101 → SRL 1001, or SRA 1011 when `in_funct7_5`=1.
  - 110 → OR 0011.
  - 111 → AND 0010.
- Illegal encodings:
  - OP with `in_funct7_5`=1 and funct3 ∉ {000, 101}.
  - OP-IMM with `in_funct7_5`=1 and funct3=001.
  - On an illegal request: `out_result`=0, `out_status`=4'b0100 (Z set), `out_illegal`=1. It still completes the handshake.
- Shift masking: for SLL/SRL/SRA, B is masked to its low $clog2(C_WIDTH) bits before the ALU sees it. For all other ops B passes unmasked.
- C and V come from the ALU unchanged: meaningful only for ADD/SUB, 0 otherwise.

## Timing
- Reset values: state=IDLE, `in_ready`=1 (it is combinational from state), `out_valid`=0, `out_result`=0, `out_status`=0, `out_illegal`=0.
- Latency: accept at edge T, result available with `out_valid`=1 at T+2.
- Throughput: one result every 2 cycles with `out_ready` tied high.
- Backpressure: while `out_ready`=0 in DONE, all outputs hold and `in_ready`=0.
- Input fields are sampled only on the accept edge; changes to them at other times have no effect.
- Reset in EXEC or DONE discards the pending request and result. The next cycle is IDLE with all outputs at reset values, and no `out_valid` pulse occurs.

## Structure
- Package `alu_pkg`: localparams for the ten ALU opcodes, funct3 codes, the FSM state enum, and the STATUS bit indices N=3, Z=2, C=1, V=0.
- One sub-module: the existing `alu`, instantiated with `C_WIDTH` and fed from the EXEC-stage operand registers.
- The decode function lives in `alu_issue`.

## Test plan
- C_WIDTH=32, OP add, A=0x7FFFFFFF, B=1, `out_ready`=1 → `out_valid` at T+2, result 0x80000000, status 4'b1001.
- OP sub (funct7_5=1), A=5, B=5 → result 0, status 4'b0110 (Z and C set, per the ALU carry rule).
- OP-IMM SRAI, funct7_5=1, A=0x80000000, B=0x21 → shift 1 after masking, result 0xC0000000, `out_illegal`=0.
- OP funct3=110 with funct7_5=1 → `out_illegal`=1, result 0, status 4'b0100.
- Hold `out_ready`=0 for 5 cycles while `in_valid`=1 → outputs stable and `in_ready`=0. Then raise `out_ready` → the old result retires and the new request is accepted on the same edge, with the new result at +2.
- Assert `rst` in EXEC → next cycle IDLE, `out_valid` never rises for that request, all outputs 0.
